// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the breadboard CPU control unit: opcodes, T-states
// and control-word bit positions.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W      = 4;
    localparam int unsigned STEP_W    = 3;
    localparam int unsigned MAX_STEPS = 5;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

    localparam int unsigned CW_HLT    = 0;
    localparam int unsigned CW_MI     = 1;
    localparam int unsigned CW_RI     = 2;
    localparam int unsigned CW_RO     = 3;
    localparam int unsigned CW_II     = 4;
    localparam int unsigned CW_IO     = 5;
    localparam int unsigned CW_AI     = 6;
    localparam int unsigned CW_AO     = 7;
    localparam int unsigned CW_EO     = 8;
    localparam int unsigned CW_SU     = 9;
    localparam int unsigned CW_BI     = 10;
    localparam int unsigned CW_OI     = 11;
    localparam int unsigned CW_FI     = 12;
    localparam int unsigned CW_PC_INC = 13;
    localparam int unsigned CW_PC_OE  = 14;
    localparam int unsigned CW_PC_JMP = 15;
    localparam int unsigned CW_W      = 16;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control-strobe bundle between the sequencer (master) and the datapath (slave).
interface control_sequencer_if import cpu_ctrl_pkg::*; ();

    logic              step_en;
    logic [OP_W-1:0]   ir_op;
    logic              carry_flag;
    logic              zero_flag;
    logic [STEP_W-1:0] step;
    logic              hlt;
    logic              mi, ri, ro, ii, io, ai, ao, eo, su, bi, oi, fi;
    logic              pc_inc, pc_oe, pc_jmp;

    modport master (
        input  step_en, ir_op, carry_flag, zero_flag,
        output step, hlt, mi, ri, ro, ii, io, ai, ao, eo, su, bi, oi, fi,
               pc_inc, pc_oe, pc_jmp
    );

    modport slave (
        output step_en, ir_op, carry_flag, zero_flag,
        input  step, hlt, mi, ri, ro, ii, io, ai, ao, eo, su, bi, oi, fi,
               pc_inc, pc_oe, pc_jmp
    );

endinterface

// File: rtl/control_rom.sv
// Microcode decode: (opcode, T-state, flags) -> control word plus a flag
// marking the last T-state of the instruction.
module control_rom import cpu_ctrl_pkg::*; (
    input  logic [OP_W-1:0]   ir_op_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              carry_flag_i,
    input  logic              zero_flag_i,
    output ctrl_word_t        cw_o,
    output logic              last_o
);

    always_comb begin
        cw_o   = '0;
        last_o = 1'b0;
        case (step_i)
            T0: begin
                cw_o[CW_PC_OE] = 1'b1;
                cw_o[CW_MI]    = 1'b1;
            end
            T1: begin
                cw_o[CW_RO]     = 1'b1;
                cw_o[CW_II]     = 1'b1;
                cw_o[CW_PC_INC] = 1'b1;
                case (ir_op_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
                    OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_o = 1'b0;
                    default:                              last_o = 1'b1;
                endcase
            end
            T2: begin
                case (ir_op_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw_o[CW_IO] = 1'b1;
                        cw_o[CW_MI] = 1'b1;
                    end
                    OP_LDI: begin
                        cw_o[CW_IO] = 1'b1;
                        cw_o[CW_AI] = 1'b1;
                        last_o      = 1'b1;
                    end
                    OP_JMP: begin
                        cw_o[CW_IO]     = 1'b1;
                        cw_o[CW_PC_JMP] = 1'b1;
                        last_o          = 1'b1;
                    end
                    // conditional jumps still end here when not taken
                    OP_JC, OP_JZ: begin
                        if ((ir_op_i == OP_JC) ? carry_flag_i : zero_flag_i) begin
                            cw_o[CW_IO]     = 1'b1;
                            cw_o[CW_PC_JMP] = 1'b1;
                        end
                        last_o = 1'b1;
                    end
                    OP_OUT: begin
                        cw_o[CW_AO] = 1'b1;
                        cw_o[CW_OI] = 1'b1;
                        last_o      = 1'b1;
                    end
                    OP_HLT:  cw_o[CW_HLT] = 1'b1;
                    default: last_o       = 1'b1;
                endcase
            end
            T3: begin
                case (ir_op_i)
                    OP_LDA: begin
                        cw_o[CW_RO] = 1'b1;
                        cw_o[CW_AI] = 1'b1;
                        last_o      = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw_o[CW_RO] = 1'b1;
                        cw_o[CW_BI] = 1'b1;
                    end
                    OP_STA: begin
                        cw_o[CW_AO] = 1'b1;
                        cw_o[CW_RI] = 1'b1;
                        last_o      = 1'b1;
                    end
                    default: last_o = 1'b1;
                endcase
            end
            T4: begin
                if (ir_op_i == OP_ADD || ir_op_i == OP_SUB) begin
                    cw_o[CW_EO] = 1'b1;
                    cw_o[CW_AI] = 1'b1;
                    cw_o[CW_FI] = 1'b1;
                    cw_o[CW_SU] = (ir_op_i == OP_SUB);
                end
                last_o = 1'b1;
            end
            default: last_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: T-state counter, halt latch and clr gating around
// the control_rom decode.
module control_sequencer import cpu_ctrl_pkg::*; (
    input  logic                 clk,
    input  logic                 clr,
    control_sequencer_if.master  bus
);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

    logic [STEP_W-1:0] step_q, step_d;
    logic              halted_q, halted_d;
    ctrl_word_t        rom_cw, cw_out;
    logic              rom_last;
    logic [STEP_W-1:0] step_out;

    control_rom u_rom (
        .ir_op_i      (bus.ir_op),
        .step_i       (step_q),
        .carry_flag_i (bus.carry_flag),
        .zero_flag_i  (bus.zero_flag),
        .cw_o         (rom_cw),
        .last_o       (rom_last)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // HLT keeps step at T2 so the frozen state is visible on the step output
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (bus.step_en && !halted_q) begin
            if (rom_cw[CW_HLT])
                halted_d = 1'b1;
            else if (rom_last || step_q == STEP_LAST)
                step_d = '0;
            else
                step_d = step_q + STEP_W'(1);
        end
    end

    always_comb begin
        cw_out   = '0;
        step_out = '0;
        if (!clr) begin
            step_out = step_q;
            if (halted_q)
                cw_out[CW_HLT] = 1'b1;
            else
                cw_out = rom_cw;
        end
    end

    assign bus.step   = step_out;
    assign bus.hlt    = cw_out[CW_HLT];
    assign bus.mi     = cw_out[CW_MI];
    assign bus.ri     = cw_out[CW_RI];
    assign bus.ro     = cw_out[CW_RO];
    assign bus.ii     = cw_out[CW_II];
    assign bus.io     = cw_out[CW_IO];
    assign bus.ai     = cw_out[CW_AI];
    assign bus.ao     = cw_out[CW_AO];
    assign bus.eo     = cw_out[CW_EO];
    assign bus.su     = cw_out[CW_SU];
    assign bus.bi     = cw_out[CW_BI];
    assign bus.oi     = cw_out[CW_OI];
    assign bus.fi     = cw_out[CW_FI];
    assign bus.pc_inc = cw_out[CW_PC_INC];
    assign bus.pc_oe  = cw_out[CW_PC_OE];
    assign bus.pc_jmp = cw_out[CW_PC_JMP];

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a micro-program reference model
// predicts step and strobes each cycle; a monitor compares what the DUT shows.
module tb_control_sequencer;

    localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000,
                            B_RO  = 16'h1000, B_II = 16'h0800, B_IO = 16'h0400,
                            B_AI  = 16'h0200, B_AO = 16'h0100, B_EO = 16'h0080,
                            B_SU  = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010,
                            B_FI  = 16'h0008, B_INC = 16'h0004, B_OE = 16'h0002,
                            B_JMP = 16'h0001;

    typedef logic [4:0][15:0] prog_t;
    typedef struct { int step; logic [15:0] word; } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_pos  = 0;
    bit   m_halt = 1'b0;

    // Each instruction is a list of strobe sets, one per T-state.
    function automatic prog_t build(input logic [3:0] op, input bit c, input bit z,
                                    output int n);
        prog_t p = '0;
        p[0] = B_OE | B_MI;
        p[1] = B_RO | B_II | B_INC;
        n = 2;
        case (op)
            4'h1: begin p[2] = B_IO | B_MI; p[3] = B_RO | B_AI; n = 4; end
            4'h2, 4'h3: begin
                p[2] = B_IO | B_MI; p[3] = B_RO | B_BI;
                p[4] = B_EO | B_AI | B_FI | ((op == 4'h3) ? B_SU : 16'h0);
                n = 5;
            end
            4'h4: begin p[2] = B_IO | B_MI; p[3] = B_AO | B_RI; n = 4; end
            4'h5: begin p[2] = B_IO | B_AI; n = 3; end
            4'h6: begin p[2] = B_IO | B_JMP; n = 3; end
            4'h7: begin p[2] = c ? (B_IO | B_JMP) : 16'h0; n = 3; end
            4'h8: begin p[2] = z ? (B_IO | B_JMP) : 16'h0; n = 3; end
            4'hE: begin p[2] = B_AO | B_OI; n = 3; end
            4'hF: begin p[2] = B_HLT; n = 3; end
            default: n = 2;
        endcase
        return p;
    endfunction

    task automatic cyc(input bit c_clr, input bit en, input logic [3:0] op,
                       input bit cf, input bit zf);
        prog_t p;
        int    n;
        exp_t  e;
        @(negedge clk);
        clr            = c_clr;
        bus.step_en    = en;
        bus.ir_op      = op;
        bus.carry_flag = cf;
        bus.zero_flag  = zf;
        #1;
        if (c_clr) begin
            m_pos = 0; m_halt = 1'b0;
            e.step = 0; e.word = '0;
        end else if (m_halt) begin
            e.step = 2; e.word = B_HLT;
        end else begin
            p = build(op, cf, zf, n);
            e.step = m_pos;
            e.word = (m_pos < n) ? p[m_pos] : 16'h0;
            if (en) begin
                if ((e.word & B_HLT) != 16'h0) m_halt = 1'b1;
                else if (m_pos + 1 >= n || m_pos + 1 >= 5) m_pos = 0;
                else m_pos = m_pos + 1;
            end
        end
        q.push_back(e);
    endtask

    initial begin
        exp_t        e;
        logic [15:0] got;
        forever begin
            @(negedge clk);
            #2;
            got = {bus.hlt, bus.mi, bus.ri, bus.ro, bus.ii, bus.io, bus.ai, bus.ao,
                   bus.eo, bus.su, bus.bi, bus.oi, bus.fi, bus.pc_inc, bus.pc_oe, bus.pc_jmp};
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty at %0t: nothing expected", $time);
            end else begin
                e = q.pop_front();
                checks++;
                if (bus.step !== 3'(e.step)) begin
                    errors++;
                    $display("FAIL step at %0t: got %0d expected %0d", $time, bus.step, e.step);
                end
                checks++;
                if (got !== e.word) begin
                    errors++;
                    $display("FAIL strobes at %0t (step %0d op %h): got %h expected %h",
                             $time, e.step, bus.ir_op, got, e.word);
                end
            end
        end
    end

    initial begin
        logic [3:0] ops [13];
        logic [3:0] cur;
        int         idx;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF, 4'hA, 4'hC};
        bus.step_en = 1'b0; bus.ir_op = 4'h0; bus.carry_flag = 1'b0; bus.zero_flag = 1'b0;

        repeat (2) cyc(1, 1, 4'h0, 0, 0);
        repeat (5) cyc(0, 1, 4'h2, 0, 0);
        repeat (5) cyc(0, 1, 4'h3, 0, 0);
        repeat (3) cyc(0, 1, 4'h2, 0, 0);
        cyc(1, 1, 4'h2, 0, 0);
        repeat (2) cyc(0, 1, 4'h0, 0, 0);
        repeat (3) cyc(0, 1, 4'h7, 0, 1);
        repeat (3) cyc(0, 1, 4'h7, 1, 0);
        repeat (3) cyc(0, 1, 4'h8, 1, 0);
        repeat (3) cyc(0, 1, 4'h8, 0, 1);
        repeat (4) cyc(0, 1, 4'h0, 1, 1);
        repeat (4) cyc(0, 1, 4'hA, 1, 1);
        repeat (4) cyc(0, 1, 4'h4, 0, 0);
        repeat (3) cyc(0, 1, 4'h5, 0, 0);
        repeat (3) cyc(0, 1, 4'h6, 0, 0);
        repeat (3) cyc(0, 1, 4'hE, 0, 0);
        repeat (3) cyc(0, 1, 4'hF, 0, 0);
        repeat (10) cyc(0, 1, 4'($urandom_range(0, 15)), 1, 1);
        cyc(1, 1, 4'h0, 0, 0);
        repeat (2) cyc(0, 1, 4'h0, 0, 0);
        repeat (3) cyc(0, 1, 4'h1, 0, 0);
        repeat (3) cyc(0, 0, 4'h1, 0, 0);
        repeat (2) cyc(0, 1, 4'h1, 0, 0);

        cur = 4'h0;
        for (int i = 0; i < 2000; i++) begin
            if ((m_halt || m_pos == 0) && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, 12);
                if (idx == 10 && $urandom_range(0, 3) != 0) idx = 2;
                cur = ops[idx];
            end
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, cur,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
